// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one external multiplier among four requesters.
// Optional WAIT watchdog enabled by defining MULT_SHARE_ARB_TIMEOUT_EN.
module mult_share_arbiter #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] req_a,
  input  logic [127:0] req_b,
  output logic [3:0]   gnt,
  output logic [3:0]   done,
  output logic [63:0]  result,
  output logic         err,
  output logic         mul_en,
  output logic [63:0]  mul_operands,
  input  logic         mul_busy,
  input  logic [63:0]  mul_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  done_q, done_d;
  logic [1:0]  winner_q, winner_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [63:0] ops_q, ops_d;
  logic [63:0] result_q, result_d;
  logic        mul_en_q, mul_en_d;
  logic        wait_first_q, wait_first_d;

  logic [31:0] a_lane [4];
  logic [31:0] b_lane [4];
  logic        pick_valid;
  logic [1:0]  pick_idx;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign a_lane[gi] = req_a[32*gi +: 32];
    assign b_lane[gi] = req_b[32*gi +: 32];
  end

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr_q + 2'(k)]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_ptr_q + 2'(k);
      end
    end
  end

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic             timeout_hit;

  // Counts WAIT cycles already spent; expires on the TIMEOUT_CYCLES-th one.
  assign wait_cnt_d  = (state_q == WAIT) ? wait_cnt_q + 1'b1 : '0;
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    winner_d     = winner_q;
    rr_ptr_d     = rr_ptr_q;
    ops_d        = ops_q;
    result_d     = result_q;
    done_d       = 4'b0;
    mul_en_d     = 1'b0;
    wait_first_d = (state_q == ISSUE);
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
    err_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = ISSUE;
          winner_d = pick_idx;
          gnt_d    = 4'b0001 << pick_idx;
          ops_d    = {a_lane[pick_idx], b_lane[pick_idx]};
          mul_en_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // The multiplier may not have raised busy yet in the first WAIT cycle.
        if (!wait_first_q && !mul_busy) begin
          state_d  = DONE;
          result_d = mul_result;
          done_d   = gnt_q;
        end
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d  = DONE;
          result_d = 64'd0;
          done_d   = gnt_q;
          err_d    = 1'b1;
        end
`endif
      end
      DONE: begin
        state_d  = IDLE;
        gnt_d    = 4'b0;
        rr_ptr_d = winner_q + 2'd1;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= 4'b0;
      done_q       <= 4'b0;
      winner_q     <= 2'd0;
      rr_ptr_q     <= 2'd0;
      ops_q        <= 64'd0;
      result_q     <= 64'd0;
      mul_en_q     <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      winner_q     <= winner_d;
      rr_ptr_q     <= rr_ptr_d;
      ops_q        <= ops_d;
      result_q     <= result_d;
      mul_en_q     <= mul_en_d;
      wait_first_q <= wait_first_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign result       = result_q;
  assign mul_en       = mul_en_q;
  assign mul_operands = ops_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural shared multiplier.
module tb_mult_share_arbiter;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] req_a, req_b;
  logic [3:0]   gnt, done;
  logic [63:0]  result;
  logic         err, mul_en;
  logic [63:0]  mul_operands;
  logic         mul_busy;
  logic [63:0]  mul_result;

  int n_checks = 0;
  int n_errors = 0;
  int busy_len = 16;
  int busy_cnt;
  logic stuck = 1'b0;

  mult_share_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .result(result), .err(err), .mul_en(mul_en),
    .mul_operands(mul_operands), .mul_busy(mul_busy), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  // Shared multiplier: busy for busy_len cycles after each start, or forever while stuck.
  assign mul_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (reset) begin
      busy_cnt   <= 0;
      mul_result <= 64'd0;
    end else if (mul_en) begin
      busy_cnt   <= busy_len;
      mul_result <= 64'(mul_operands[63:32]) * 64'(mul_operands[31:0]);
    end else if (busy_cnt != 0 && !stuck) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      check("done_within_gnt", 64'((done & ~gnt) == 4'b0), 64'd1);
      check("err_without_done", 64'(err && done == 4'b0), 64'd0);
    end
  end

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // Called at a negedge with req already driven; returns one cycle after done.
  task automatic run_op(input string tag, input logic [3:0] eg, input logic [63:0] eops,
                        input logic [63:0] eres, input logic eerr, input int elat,
                        input bit scramble, input bit drop);
    int n;
    int en_cnt;
    logic pb, ppb;
    logic [63:0] res_seen;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 4'b0 && n < 50);
    check({tag, "/req_to_issue"}, 64'(n), 64'd1);
    check({tag, "/gnt"}, 64'(gnt), 64'(eg));
    check({tag, "/mul_en"}, 64'(mul_en), 64'd1);
    check({tag, "/ops_issue"}, mul_operands, eops);
    if (scramble) begin req_a = ~req_a; req_b = ~req_b; end
    if (drop) req = 4'b0;
    en_cnt = 1; pb = 1'b1; ppb = 1'b1; n = 0;
    while (done == 4'b0 && n < 200) begin
      ppb = pb; pb = mul_busy;
      @(negedge clk); n++;
      if (mul_en) en_cnt++;
    end
    check({tag, "/latency"}, 64'(n), 64'(elat));
    check({tag, "/done"}, 64'(done), 64'(eg));
    check({tag, "/err"}, 64'(err), 64'(eerr));
    check({tag, "/result"}, result, eres);
    check({tag, "/ops_hold"}, mul_operands, eops);
    check({tag, "/mul_en_count"}, 64'(en_cnt), 64'd1);
    check({tag, "/gnt_in_done"}, 64'(gnt), 64'(eg));
    if (!eerr) check({tag, "/busy_fall_to_done"}, 64'({ppb, pb}), 64'd2);
    else       check({tag, "/busy_still_high"}, 64'(pb), 64'd1);
    res_seen = result;
    @(negedge clk);
    check({tag, "/done_clear"}, 64'(done), 64'd0);
    check({tag, "/err_clear"}, 64'(err), 64'd0);
    check({tag, "/gnt_clear"}, 64'(gnt), 64'd0);
    check({tag, "/result_stable"}, result, res_seen);
    $display("op %s: gnt=%b result=0x%h err=%0d latency=%0d", tag, eg, res_seen, eerr, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] done_seen;
    reset = 1'b1; req = 4'b0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    check("reset/gnt", 64'(gnt), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/err", 64'(err), 64'd0);
    check("reset/mul_en", 64'(mul_en), 64'd0);
    check("reset/result", result, 64'd0);
    check("reset/mul_operands", mul_operands, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_req/gnt", 64'(gnt), 64'd0);
    check("idle_no_req/mul_en", 64'(mul_en), 64'd0);

    // Single request, operands corrupted after the grant.
    busy_len = 16;
    set_ops(0, 32'd3, 32'd5); req = 4'b0001;
    run_op("single", 4'b0001, {32'd3, 32'd5}, 64'h0000_0000_0000_000F, 1'b0, 18, 1'b1, 1'b0);
    req = 4'b0;

    // Full-width product on requester 2 (rr_ptr is 1, so 1 is skipped).
    set_ops(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); req = 4'b0100;
    run_op("fullwidth", 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 18, 1'b0, 1'b0);
    req = 4'b0;

    // After requester 2, requester 3 beats requester 0; 0's req drops mid-op.
    set_ops(3, 32'd7, 32'd9); set_ops(0, 32'h0001_0000, 32'h0001_0000); req = 4'b1001;
    run_op("rr_3", 4'b1000, {32'd7, 32'd9}, 64'd63, 1'b0, 18, 1'b0, 1'b0);
    run_op("rr_0_drop", 4'b0001, {32'h0001_0000, 32'h0001_0000}, 64'h0000_0001_0000_0000, 1'b0, 18, 1'b0, 1'b1);
    req = 4'b0;

    // Reset in the 5th WAIT cycle.
    set_ops(1, 32'h1234, 32'h5678); req = 4'b0010;
    @(negedge clk);
    check("rst_wait/gnt", 64'(gnt), 64'd2);
    repeat (5) @(negedge clk);
    reset = 1'b1; req = 4'b0;
    @(negedge clk);
    check("rst_wait/gnt_after", 64'(gnt), 64'd0);
    check("rst_wait/done_after", 64'(done), 64'd0);
    check("rst_wait/err_after", 64'(err), 64'd0);
    check("rst_wait/mul_en_after", 64'(mul_en), 64'd0);
    check("rst_wait/result_after", result, 64'd0);
    check("rst_wait/ops_after", mul_operands, 64'd0);
    reset = 1'b0;
    done_seen = 4'b0;
    repeat (25) begin @(negedge clk); done_seen |= done; end
    check("rst_wait/no_done", 64'(done_seen), 64'd0);
    $display("op rst_wait: reset in WAIT, no done observed=%b", done_seen);

    // All four requesting continuously from reset.
    reset = 1'b1; req = 4'b1111; busy_len = 3;
    for (int i = 0; i < 4; i++) set_ops(i, 32'(i + 1), 32'd10);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_op("all_0", 4'b0001, {32'd1, 32'd10}, 64'd10, 1'b0, 5, 1'b0, 1'b0);
    run_op("all_1", 4'b0010, {32'd2, 32'd10}, 64'd20, 1'b0, 5, 1'b0, 1'b0);
    run_op("all_2", 4'b0100, {32'd3, 32'd10}, 64'd30, 1'b0, 5, 1'b0, 1'b0);
    run_op("all_3", 4'b1000, {32'd4, 32'd10}, 64'd40, 1'b0, 5, 1'b0, 1'b0);
    run_op("all_0b", 4'b0001, {32'd1, 32'd10}, 64'd10, 1'b0, 5, 1'b0, 1'b0);
    req = 4'b0;

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
    // Stuck multiplier times out, then the next requester is served normally.
    busy_len = 16; stuck = 1'b1; req = 4'b0110;
    run_op("timeout", 4'b0010, {32'd2, 32'd10}, 64'd0, 1'b1, TO + 1, 1'b0, 1'b0);
    stuck = 1'b0;
    run_op("after_timeout", 4'b0100, {32'd3, 32'd10}, 64'd30, 1'b0, 18, 1'b0, 1'b0);
    req = 4'b0;
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
